// File: rtl/branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// branch_resolve_bht
//   Resolves branch/jump direction for the instruction in EX, compares it with
//   the direction predicted at IF and flags mispredictions. Owns a table of
//   2-bit saturating counters (read at IF, trained at EX) and two performance
//   counters.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   if_pc             fetch PC, indexes the table for if_pred_taken
//   if_pred_taken     predicted direction (MSB of the indexed counter)
//   ex_valid          EX holds a valid instruction
//   ex_pc, ex_instr   PC and instruction word in EX
//   ex_pred_taken     prediction carried down from IF
//   ex_zero/lt/ltu    ALU flags: equal, signed less-than, unsigned less-than
//   bht_clear         synchronous reinitialisation of the table to 01
//   ex_taken          resolved direction
//   ex_mispredict     resolved direction differs from prediction
//   flush_q           registered ex_mispredict
//   illegal_br        branch opcode with reserved funct3 (010/011)
//   perf_branches     count of resolved jumps and legal branches
//   perf_mispredicts  count of mispredictions
// -----------------------------------------------------------------------------
module branch_resolve_bht #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int INDEX_LSB   = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [31:0]      ex_instr,
    input  logic             ex_pred_taken,
    input  logic             ex_zero,
    input  logic             ex_lt,
    input  logic             ex_ltu,
    input  logic             bht_clear,
    output logic             ex_taken,
    output logic             ex_mispredict,
    output logic             flush_q,
    output logic             illegal_br,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    localparam int         IDX_W     = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [1:0]       r_bht [BHT_ENTRIES];
    logic             r_flush;
    logic [CNT_W-1:0] r_perf_br;
    logic [CNT_W-1:0] r_perf_mp;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_cond;
    logic             w_taken;
    logic             w_mispredict;
    logic             w_illegal;
    logic             w_count;
    logic             w_update;
    logic [1:0]       w_bht_cur;
    logic [1:0]       w_bht_nxt;

    // Only the index bits of the PCs and the opcode/funct3 fields are used.
    logic w_unused_bits;
    assign w_unused_bits = ^{if_pc, ex_pc, ex_instr};

    assign w_opcode = ex_instr[6:0];
    assign w_funct3 = ex_instr[14:12];
    assign w_if_idx = if_pc[INDEX_LSB +: IDX_W];
    assign w_ex_idx = ex_pc[INDEX_LSB +: IDX_W];

    always_comb begin
        w_cond = 1'b0;
        case (w_funct3)
            3'b000:  w_cond = ex_zero;
            3'b001:  w_cond = !ex_zero;
            3'b100:  w_cond = ex_lt;
            3'b101:  w_cond = !ex_lt;
            3'b110:  w_cond = ex_ltu;
            3'b111:  w_cond = !ex_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_taken      = 1'b0;
        w_mispredict = 1'b0;
        w_illegal    = 1'b0;
        w_count      = 1'b0;
        w_update     = 1'b0;
        if (ex_valid) begin
            if (w_opcode == OP_JAL) begin
                w_taken      = 1'b1;
                w_mispredict = !ex_pred_taken;
                w_count      = 1'b1;
            end else if (w_opcode == OP_JALR) begin
                // Target is unknown at IF, so a JALR always redirects.
                w_taken      = 1'b1;
                w_mispredict = 1'b1;
                w_count      = 1'b1;
            end else if (w_opcode == OP_BRANCH) begin
                if (w_funct3[2:1] == 2'b01) begin
                    w_illegal = 1'b1;
                end else begin
                    w_taken      = w_cond;
                    w_mispredict = (w_cond != ex_pred_taken);
                    w_count      = 1'b1;
                    w_update     = 1'b1;
                end
            end
        end
    end

    assign w_bht_cur = r_bht[w_ex_idx];

    always_comb begin
        w_bht_nxt = w_bht_cur;
        if (w_taken) begin
            if (w_bht_cur != 2'b11) w_bht_nxt = w_bht_cur + 2'b01;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_nxt = w_bht_cur - 2'b01;
        end
    end

    // Clear wins over a same-cycle training update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else if (bht_clear) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else if (w_update) begin
            r_bht[w_ex_idx] <= w_bht_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush   <= 1'b0;
            r_perf_br <= '0;
            r_perf_mp <= '0;
        end else begin
            r_flush <= w_mispredict;
            if (w_count)      r_perf_br <= r_perf_br + CNT_W'(1);
            if (w_mispredict) r_perf_mp <= r_perf_mp + CNT_W'(1);
        end
    end

    // Read is not bypassed: a same-cycle update is visible only after the edge.
    assign if_pred_taken    = r_bht[w_if_idx][1];
    assign ex_taken         = w_taken;
    assign ex_mispredict    = w_mispredict;
    assign illegal_br       = w_illegal;
    assign flush_q          = r_flush;
    assign perf_branches    = r_perf_br;
    assign perf_mispredicts = r_perf_mp;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_bht
//   Directed bench for branch_resolve_bht. A second instance with 2-bit perf
//   counters shares all inputs so counter wrap is reachable in a few events.
// -----------------------------------------------------------------------------
module tb_branch_resolve_bht;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic        ex_pred_taken;
    logic        ex_zero, ex_lt, ex_ltu;
    logic        bht_clear;

    logic        if_pred_taken, ex_taken, ex_mispredict, flush_q, illegal_br;
    logic [31:0] perf_branches, perf_mispredicts;

    logic        s_if_pred_taken, s_ex_taken, s_ex_mispredict, s_flush_q, s_illegal_br;
    logic [1:0]  s_perf_branches, s_perf_mispredicts;

    int checks   = 0;
    int failures = 0;
    int exp_br   = 0;
    int exp_mp   = 0;

    always #5 clk = ~clk;

    branch_resolve_bht dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_pred_taken(ex_pred_taken), .ex_zero(ex_zero), .ex_lt(ex_lt),
        .ex_ltu(ex_ltu), .bht_clear(bht_clear), .ex_taken(ex_taken),
        .ex_mispredict(ex_mispredict), .flush_q(flush_q), .illegal_br(illegal_br),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    branch_resolve_bht #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(s_if_pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_pred_taken(ex_pred_taken), .ex_zero(ex_zero), .ex_lt(ex_lt),
        .ex_ltu(ex_ltu), .bht_clear(bht_clear), .ex_taken(s_ex_taken),
        .ex_mispredict(s_ex_mispredict), .flush_q(s_flush_q), .illegal_br(s_illegal_br),
        .perf_branches(s_perf_branches), .perf_mispredicts(s_perf_mispredicts)
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic idle();
        ex_valid      = 1'b0;
        ex_pc         = 32'h0;
        ex_instr      = 32'h0;
        ex_pred_taken = 1'b0;
        ex_zero       = 1'b0;
        ex_lt         = 1'b0;
        ex_ltu        = 1'b0;
        bht_clear     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        if_pc = 32'h40;
        #3;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b want=0", if_pred_taken); end
        checks++; if (flush_q !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b want=0", flush_q); end
        checks++; if (perf_branches !== 32'd0) begin failures++; $display("FAIL reset_perf_br got=%0d want=0", perf_branches); end
        checks++; if (perf_mispredicts !== 32'd0) begin failures++; $display("FAIL reset_perf_mp got=%0d want=0", perf_mispredicts); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_training();
        if_pc         = 32'h40;
        ex_pc         = 32'h40;
        ex_instr      = mk(OP_BRANCH, 3'b000);
        ex_zero       = 1'b1;
        ex_pred_taken = 1'b0;
        ex_valid      = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (ex_taken !== 1'b1) begin failures++; $display("FAIL train_taken c=%0d got=%b want=1", c, ex_taken); end
            checks++; if (ex_mispredict !== 1'b1) begin failures++; $display("FAIL train_mispredict c=%0d got=%b want=1", c, ex_mispredict); end
            if (c == 1) begin
                checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL read_during_write got=%b want=0", if_pred_taken); end
            end
            next_cycle();
            exp_br++; exp_mp++;
            checks++; if (flush_q !== 1'b1) begin failures++; $display("FAIL train_flush c=%0d got=%b want=1", c, flush_q); end
            checks++; if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL train_pred c=%0d got=%b want=1", c, if_pred_taken); end
        end
        // Two not-taken steps: saturated 11 -> 10 -> 01.
        ex_zero = 1'b0;
        #1;
        checks++; if (ex_mispredict !== 1'b0) begin failures++; $display("FAIL nt_mispredict got=%b want=0", ex_mispredict); end
        next_cycle();
        exp_br++;
        checks++; if (flush_q !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b want=0", flush_q); end
        checks++; if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL sat_step1 got=%b want=1", if_pred_taken); end
        next_cycle();
        exp_br++;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL sat_step2 got=%b want=0", if_pred_taken); end
        checks++; if (perf_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL train_perf_mp got=%0d want=%0d", perf_mispredicts, exp_mp); end
        checks++; if (perf_branches !== 32'(exp_br)) begin failures++; $display("FAIL train_perf_br got=%0d want=%0d", perf_branches, exp_br); end
        idle();
    endtask

    task automatic test_aliasing();
        if_pc         = 32'h000;
        ex_pc         = 32'h100;
        ex_instr      = mk(OP_BRANCH, 3'b001);
        ex_zero       = 1'b0;
        ex_pred_taken = 1'b0;
        ex_valid      = 1'b1;
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL alias_before got=%b want=0", if_pred_taken); end
        next_cycle();
        exp_br++; exp_mp++;
        idle();
        #1;
        checks++; if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL alias_0x000 got=%b want=1", if_pred_taken); end
        if_pc = 32'h40;
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL alias_other_idx got=%b want=0", if_pred_taken); end
    endtask

    task automatic test_matrix();
        logic [2:0] f3  [12] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b100,
                                 3'b101, 3'b101, 3'b110, 3'b110, 3'b111, 3'b111};
        logic [2:0] flg [12] = '{3'b100, 3'b010, 3'b000, 3'b100, 3'b010, 3'b001,
                                 3'b010, 3'b001, 3'b001, 3'b010, 3'b010, 3'b001};
        logic       tk  [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       pr;
        logic       mis;
        ex_pc    = 32'h300;
        ex_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ex_instr = mk(OP_BRANCH, f3[i]);
            {ex_zero, ex_lt, ex_ltu} = flg[i];
            pr = (i % 3 == 0);
            ex_pred_taken = pr;
            mis = (tk[i] != pr);
            #1;
            checks++; if (ex_taken !== tk[i]) begin failures++; $display("FAIL matrix_taken i=%0d f3=%b got=%b want=%b", i, f3[i], ex_taken, tk[i]); end
            checks++; if (ex_mispredict !== mis) begin failures++; $display("FAIL matrix_mispredict i=%0d got=%b want=%b", i, ex_mispredict, mis); end
            next_cycle();
            exp_br++;
            if (mis) exp_mp++;
        end
        idle();
        checks++; if (perf_branches !== 32'(exp_br)) begin failures++; $display("FAIL matrix_perf_br got=%0d want=%0d", perf_branches, exp_br); end
        checks++; if (perf_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL matrix_perf_mp got=%0d want=%0d", perf_mispredicts, exp_mp); end
    endtask

    task automatic test_jumps();
        if_pc         = 32'h80;
        ex_pc         = 32'h80;
        ex_valid      = 1'b1;
        ex_pred_taken = 1'b1;
        ex_instr      = mk(OP_JALR, 3'b000);
        #1;
        checks++; if (ex_taken !== 1'b1) begin failures++; $display("FAIL jalr_taken got=%b want=1", ex_taken); end
        checks++; if (ex_mispredict !== 1'b1) begin failures++; $display("FAIL jalr_mispredict got=%b want=1", ex_mispredict); end
        next_cycle();
        exp_br++; exp_mp++;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL jalr_no_train got=%b want=0", if_pred_taken); end
        ex_instr = mk(OP_JAL, 3'b000);
        #1;
        checks++; if (ex_mispredict !== 1'b0) begin failures++; $display("FAIL jal_mispredict got=%b want=0", ex_mispredict); end
        next_cycle();
        exp_br++;
        checks++; if (flush_q !== 1'b0) begin failures++; $display("FAIL jal_flush got=%b want=0", flush_q); end
        ex_pred_taken = 1'b0;
        ex_zero       = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ex_instr = mk(OP_BRANCH, (k == 0) ? 3'b010 : 3'b011);
            #1;
            checks++; if (illegal_br !== 1'b1) begin failures++; $display("FAIL illegal_flag k=%0d got=%b want=1", k, illegal_br); end
            checks++; if (ex_taken !== 1'b0) begin failures++; $display("FAIL illegal_taken k=%0d got=%b want=0", k, ex_taken); end
            next_cycle();
        end
        ex_instr      = mk(OP_ALU, 3'b000);
        ex_pred_taken = 1'b1;
        #1;
        checks++; if ({ex_taken, ex_mispredict, illegal_br} !== 3'b000) begin failures++; $display("FAIL non_cf got=%b want=000", {ex_taken, ex_mispredict, illegal_br}); end
        next_cycle();
        ex_valid = 1'b0;
        ex_instr = mk(OP_JALR, 3'b000);
        #1;
        checks++; if ({ex_taken, ex_mispredict} !== 2'b00) begin failures++; $display("FAIL invalid_gate got=%b want=00", {ex_taken, ex_mispredict}); end
        next_cycle();
        checks++; if (perf_branches !== 32'(exp_br)) begin failures++; $display("FAIL jumps_perf_br got=%0d want=%0d", perf_branches, exp_br); end
        checks++; if (perf_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL jumps_perf_mp got=%0d want=%0d", perf_mispredicts, exp_mp); end
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL jumps_table got=%b want=0", if_pred_taken); end
        idle();
    endtask

    task automatic test_clear();
        if_pc         = 32'h40;
        ex_pc         = 32'h40;
        ex_instr      = mk(OP_BRANCH, 3'b000);
        ex_zero       = 1'b1;
        ex_pred_taken = 1'b0;
        ex_valid      = 1'b1;
        next_cycle();
        exp_br++; exp_mp++;
        checks++; if (if_pred_taken !== 1'b1) begin failures++; $display("FAIL clear_pretrain got=%b want=1", if_pred_taken); end
        bht_clear = 1'b1;
        next_cycle();
        exp_br++; exp_mp++;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL clear_overrides got=%b want=0", if_pred_taken); end
        idle();
        if_pc = 32'h000;
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL clear_idx0 got=%b want=0", if_pred_taken); end
        checks++; if (perf_branches !== 32'(exp_br)) begin failures++; $display("FAIL clear_perf_br got=%0d want=%0d", perf_branches, exp_br); end
        checks++; if (perf_mispredicts !== 32'(exp_mp)) begin failures++; $display("FAIL clear_perf_mp got=%0d want=%0d", perf_mispredicts, exp_mp); end
    endtask

    task automatic test_async_reset();
        if_pc         = 32'h40;
        ex_pc         = 32'h40;
        ex_instr      = mk(OP_BRANCH, 3'b000);
        ex_zero       = 1'b1;
        ex_pred_taken = 1'b0;
        ex_valid      = 1'b1;
        next_cycle();
        checks++; if ({if_pred_taken, flush_q} !== 2'b11) begin failures++; $display("FAIL arst_setup got=%b want=11", {if_pred_taken, flush_q}); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL arst_pred got=%b want=0", if_pred_taken); end
        checks++; if (flush_q !== 1'b0) begin failures++; $display("FAIL arst_flush got=%b want=0", flush_q); end
        checks++; if (perf_branches !== 32'd0) begin failures++; $display("FAIL arst_perf_br got=%0d want=0", perf_branches); end
        checks++; if (perf_mispredicts !== 32'd0) begin failures++; $display("FAIL arst_perf_mp got=%0d want=0", perf_mispredicts); end
        next_cycle();
        checks++; if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL arst_discard got=%b want=0", if_pred_taken); end
        idle();
        rst_n  = 1'b1;
        exp_br = 0;
        exp_mp = 0;
    endtask

    task automatic test_wrap();
        ex_pc         = 32'h80;
        ex_instr      = mk(OP_JALR, 3'b000);
        ex_pred_taken = 1'b0;
        ex_valid      = 1'b1;
        for (int k = 0; k < 3; k++) next_cycle();
        checks++; if ({s_perf_branches, s_perf_mispredicts} !== 4'b1111) begin failures++; $display("FAIL wrap_preset got=%b want=1111", {s_perf_branches, s_perf_mispredicts}); end
        next_cycle();
        idle();
        checks++; if (s_perf_branches !== 2'd0) begin failures++; $display("FAIL wrap_br got=%0d want=0", s_perf_branches); end
        checks++; if (s_perf_mispredicts !== 2'd0) begin failures++; $display("FAIL wrap_mp got=%0d want=0", s_perf_mispredicts); end
        checks++; if (perf_branches !== 32'd4) begin failures++; $display("FAIL wrap_wide got=%0d want=4", perf_branches); end
    endtask

    initial begin
        test_reset();
        test_training();
        test_aliasing();
        test_matrix();
        test_jumps();
        test_clear();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
